// File: rtl/perimeter_arbiter.sv
// perimeter_arbiter: shares one perimeter unit (p = 2*(a+b), dav_/rfd
// four-phase handshake) between two requesters with round-robin grant.
// Each requester sees a perimeter-unit-like interface with its own
// registered result; only one transaction is in flight at a time.
//
// Optional build macro: PERIM_ARB_TIMEOUT_EN
//   When defined, every cycle spent in ISSUE/RELEASE is counted, and a
//   stalled unit handshake is abandoned after TIMEOUT cycles. The granted
//   requester's sticky err flag is raised, its result is left untouched,
//   and the arbiter returns to IDLE. When undefined, the unit handshake
//   waits forever and err0/err1 are tied low.

module perimeter_arbiter #(
  parameter int A_W     = 4,
  parameter int P_W     = 6,
  parameter int TIMEOUT = 255
) (
  input  logic           clock,
  input  logic           reset_,
  // requester 0
  input  logic [A_W-1:0] a0,
  input  logic [A_W-1:0] b0,
  input  logic           dav0_,
  output logic           rfd0,
  output logic [P_W-1:0] p0,
  // requester 1
  input  logic [A_W-1:0] a1,
  input  logic [A_W-1:0] b1,
  input  logic           dav1_,
  output logic           rfd1,
  output logic [P_W-1:0] p1,
  // shared perimeter unit
  output logic [A_W-1:0] u_a,
  output logic [A_W-1:0] u_b,
  output logic           u_dav_,
  input  logic           u_rfd,
  input  logic [P_W-1:0] u_p,
  // timeout flags
  output logic           err0,
  output logic           err1
);

  typedef enum logic [2:0] {
    IDLE,
    GRANT,
    WAIT_DAV,
    ISSUE,
    RELEASE,
    DONE
  } state_t;

  state_t state;
  state_t state_next;

  // grant: requester currently owning the unit (0 or 1)
  logic grant;
  logic grant_next;
  // last_grant: requester served most recently, used to break ties
  logic last_grant;
  // armed: unit was seen ready while in ISSUE, so u_dav_ may be asserted
  logic armed;
  // data-available of the granted requester
  logic dav_g;
  // unit handshake abandoned this cycle
  logic timeout_fire;
  // the unit handshake makes progress this cycle
  logic progress;
  logic busy;

  assign dav_g    = grant ? dav1_ : dav0_;
  assign progress = ((state == ISSUE) && armed && !u_rfd) ||
                    ((state == RELEASE) && u_rfd);

`ifdef PERIM_ARB_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

  logic [CNT_W-1:0] cnt;
  logic             err0_q;
  logic             err1_q;

  // Fires when the current ISSUE/RELEASE stay has lasted TIMEOUT cycles
  // without the unit moving the handshake on.
  assign timeout_fire = ((state == ISSUE) || (state == RELEASE)) &&
                        !progress && (cnt == CNT_W'(TIMEOUT - 1));

  // Cycle counter for the unit handshake, restarted on every state change
  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      cnt <= '0;
    end else if (state_next != state) begin
      cnt <= '0;
    end else if ((state == ISSUE) || (state == RELEASE)) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Sticky per-requester timeout flags, cleared only by reset
  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      err0_q <= 1'b0;
      err1_q <= 1'b0;
    end else if (timeout_fire) begin
      if (grant) begin
        err1_q <= 1'b1;
      end else begin
        err0_q <= 1'b1;
      end
    end
  end

  assign err0 = err0_q;
  assign err1 = err1_q;
`else
  logic unused_timeout;

  assign unused_timeout = ^TIMEOUT;
  assign timeout_fire   = 1'b0;
  assign err0           = 1'b0;
  assign err1           = 1'b0;
`endif

  // State register together with the owner of the current transaction
  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      state <= IDLE;
      grant <= 1'b0;
    end else begin
      state <= state_next;
      grant <= grant_next;
    end
  end

  // Next-state logic: arbitration in IDLE, then the two handshakes in order
  always_comb begin
    state_next = state;
    grant_next = grant;
    case (state)
      IDLE: begin
        if (!dav0_ && !dav1_) begin
          grant_next = ~last_grant;
          state_next = GRANT;
        end else if (!dav0_) begin
          grant_next = 1'b0;
          state_next = GRANT;
        end else if (!dav1_) begin
          grant_next = 1'b1;
          state_next = GRANT;
        end
      end
      GRANT: begin
        state_next = WAIT_DAV;
      end
      WAIT_DAV: begin
        if (dav_g) begin
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        if (armed && !u_rfd) begin
          state_next = RELEASE;
        end else if (timeout_fire) begin
          state_next = IDLE;
        end
      end
      RELEASE: begin
        if (u_rfd) begin
          state_next = DONE;
        end else if (timeout_fire) begin
          state_next = IDLE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Handshake outputs decoded from the state and the current owner
  always_comb begin
    busy   = (state == GRANT) || (state == WAIT_DAV) ||
             (state == ISSUE) || (state == RELEASE);
    rfd0   = !(busy && !grant);
    rfd1   = !(busy && grant);
    u_dav_ = !((state == ISSUE) && armed);
  end

  // Arm the unit request only once the unit has been seen ready in ISSUE
  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      armed <= 1'b0;
    end else begin
      armed <= (state_next == ISSUE) &&
               ((state == ISSUE) ? (armed || u_rfd) : u_rfd);
    end
  end

  // Round-robin memory, updated once the grant is committed
  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      last_grant <= 1'b1;
    end else if (state == GRANT) begin
      last_grant <= grant;
    end
  end

  // Operand capture on the arbitration edge, while dav_ still guarantees them
  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      u_a <= '0;
      u_b <= '0;
    end else if ((state == IDLE) && (state_next == GRANT)) begin
      u_a <= grant_next ? a1 : a0;
      u_b <= grant_next ? b1 : b0;
    end
  end

  // Result capture for the owner when the unit completes its handshake
  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      p0 <= '0;
      p1 <= '0;
    end else if ((state == RELEASE) && u_rfd) begin
      if (grant) begin
        p1 <= u_p;
      end else begin
        p0 <= u_p;
      end
    end
  end

endmodule

// File: tb/tb_perimeter_arbiter.sv
// tb_perimeter_arbiter: randomized self-checking bench for perimeter_arbiter.
// A behavioural perimeter unit answers the shared handshake; expected
// results and service order come from plain arithmetic and a round-robin
// memory kept in the bench.

module tb_perimeter_arbiter;

  logic       clock = 1'b0;
  logic       reset_;
  logic [3:0] a0, b0, a1, b1;
  logic       dav0_, dav1_;
  logic       rfd0, rfd1;
  logic [5:0] p0, p1;
  logic [3:0] u_a, u_b;
  logic       u_dav_;
  logic       u_rfd;
  logic [5:0] u_p;
  logic       err0, err1;

  int tests  = 0;
  int failed = 0;
  int cyc    = 0;

  // reference model state: requester that was served last
  int lg_model = 1;

  // unit model controls
  int  fall_delay = 0;
  int  rise_delay = 0;
  bit  unit_stuck = 0;
  int  ust = 0;
  int  ucnt = 0;
  logic [5:0] lat_p;

  // monitor: the idle requester must keep rfd=1 and its result unchanged
  bit         mon_en = 0;
  int         mon_idx = 1;
  logic [5:0] mon_p = '0;
  int         mon_bad = 0;

  perimeter_arbiter #(.A_W(4), .P_W(6), .TIMEOUT(20)) dut (
    .clock (clock),
    .reset_(reset_),
    .a0    (a0),
    .b0    (b0),
    .dav0_ (dav0_),
    .rfd0  (rfd0),
    .p0    (p0),
    .a1    (a1),
    .b1    (b1),
    .dav1_ (dav1_),
    .rfd1  (rfd1),
    .p1    (p1),
    .u_a   (u_a),
    .u_b   (u_b),
    .u_dav_(u_dav_),
    .u_rfd (u_rfd),
    .u_p   (u_p),
    .err0  (err0),
    .err1  (err1)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [5:0] perim(input logic [3:0] a, input logic [3:0] b);
    int s;
    s = 2 * (int'(a) + int'(b));
    return s[5:0];
  endfunction

  // Behavioural perimeter unit on the shared side
  initial begin
    int tmp;
    u_rfd = 1'b1;
    u_p   = '0;
    forever begin
      @(negedge clock);
      if (!reset_) begin
        ust   = 0;
        u_rfd = 1'b1;
      end else begin
        case (ust)
          0: if (u_dav_ == 1'b0 && u_rfd == 1'b1) begin
               tmp   = 2 * (int'(u_a) + int'(u_b));
               lat_p = tmp[5:0];
               ucnt  = 0;
               ust   = 1;
             end
          1: if (ucnt >= fall_delay) begin
               u_p   = lat_p;
               u_rfd = 1'b0;
               ust   = 2;
             end else ucnt++;
          2: if (u_dav_ == 1'b1) begin
               ucnt = 0;
               ust  = 3;
             end
          3: if (!unit_stuck) begin
               if (ucnt >= rise_delay) begin
                 u_rfd = 1'b1;
                 ust   = 0;
               end else ucnt++;
             end
          default: ust = 0;
        endcase
      end
    end
  end

  always @(negedge clock) begin
    if (mon_en) begin
      if (mon_idx == 0) begin
        if (rfd0 !== 1'b1 || p0 !== mon_p) mon_bad++;
      end else begin
        if (rfd1 !== 1'b1 || p1 !== mon_p) mon_bad++;
      end
    end
  end

  task automatic apply_reset();
    @(negedge clock);
    reset_ = 1'b0;
    dav0_  = 1'b1;
    dav1_  = 1'b1;
    repeat (2) @(negedge clock);
    reset_   = 1'b1;
    lg_model = 1;
  endtask

  // One full requester transaction; starts and ends on a negedge
  task automatic request(input int idx, input logic [3:0] a, input logic [3:0] b,
                         output int low_cycles, output int done_cyc,
                         output logic [5:0] p_seen, output bit ok);
    bit seen;
    int n;
    ok = 1'b0;
    low_cycles = 0;
    done_cyc = 0;
    p_seen = '0;
    if (idx == 0) begin a0 = a; b0 = b; dav0_ = 1'b0; end
    else          begin a1 = a; b1 = b; dav1_ = 1'b0; end
    seen = 1'b0;
    n = 0;
    while (n < 2000 && !seen) begin
      @(negedge clock);
      n++;
      if (((idx == 0) ? rfd0 : rfd1) == 1'b0) seen = 1'b1;
    end
    if (idx == 0) begin dav0_ = 1'b1; a0 = 4'($urandom); b0 = 4'($urandom); end
    else          begin dav1_ = 1'b1; a1 = 4'($urandom); b1 = 4'($urandom); end
    if (!seen) return;
    low_cycles = 1;
    seen = 1'b0;
    n = 0;
    while (n < 2000 && !seen) begin
      @(negedge clock);
      n++;
      if (((idx == 0) ? rfd0 : rfd1) == 1'b1) seen = 1'b1;
      else low_cycles++;
    end
    done_cyc = cyc;
    p_seen = (idx == 0) ? p0 : p1;
    ok = seen;
  endtask

  task automatic single_checked(input int idx, input logic [3:0] a, input logic [3:0] b,
                                input string name);
    int lc, dc;
    logic [5:0] ps;
    bit ok;
    mon_idx = 1 - idx;
    mon_p   = (idx == 0) ? p1 : p0;
    mon_bad = 0;
    mon_en  = 1'b1;
    request(idx, a, b, lc, dc, ps, ok);
    mon_en  = 1'b0;
    tests++;
    if (!ok) begin
      failed++;
      $display("[TB] FAIL %s handshake: rfd%0d never completed", name, idx);
    end
    tests++;
    if (ps !== perim(a, b)) begin
      failed++;
      $display("[TB] FAIL %s result: p%0d=%0d expected %0d", name, idx, ps, perim(a, b));
    end
    tests++;
    if (mon_bad != 0) begin
      failed++;
      $display("[TB] FAIL %s idle side: %0d cycles with rfd%0d!=1 or p changed, expected 0",
               name, mon_bad, 1 - idx);
    end
    lg_model = idx;
  endtask

  task automatic pair_checked(input logic [3:0] a0v, input logic [3:0] b0v,
                              input logic [3:0] a1v, input logic [3:0] b1v,
                              input string name);
    int lc0, lc1, dc0, dc1, first_exp, first_act;
    logic [5:0] ps0, ps1;
    bit ok0, ok1;
    first_exp = (lg_model == 1) ? 0 : 1;
    fork
      request(0, a0v, b0v, lc0, dc0, ps0, ok0);
      request(1, a1v, b1v, lc1, dc1, ps1, ok1);
    join
    tests++;
    if (!ok0 || !ok1) begin
      failed++;
      $display("[TB] FAIL %s handshake: done0=%0d done1=%0d expected both 1", name, ok0, ok1);
    end
    tests++;
    if (ps0 !== perim(a0v, b0v)) begin
      failed++;
      $display("[TB] FAIL %s p0: got %0d expected %0d", name, ps0, perim(a0v, b0v));
    end
    tests++;
    if (ps1 !== perim(a1v, b1v)) begin
      failed++;
      $display("[TB] FAIL %s p1: got %0d expected %0d", name, ps1, perim(a1v, b1v));
    end
    first_act = (dc0 < dc1) ? 0 : 1;
    tests++;
    if (first_act != first_exp) begin
      failed++;
      $display("[TB] FAIL %s order: first served req%0d expected req%0d", name, first_act, first_exp);
    end
    lg_model = 1 - first_exp;
  endtask

  task automatic test_reset();
    reset_ = 1'b0;
    #1;
    tests++;
    if ({rfd0, rfd1, u_dav_, err0, err1} !== 5'b11100) begin
      failed++;
      $display("[TB] FAIL reset flags: rfd0,rfd1,u_dav_,err0,err1=%b expected 11100",
               {rfd0, rfd1, u_dav_, err0, err1});
    end
    tests++;
    if ({p0, p1, u_a, u_b} !== 20'd0) begin
      failed++;
      $display("[TB] FAIL reset data: p0=%0d p1=%0d u_a=%0d u_b=%0d expected all 0", p0, p1, u_a, u_b);
    end
    apply_reset();
  endtask

  task automatic test_single();
    single_checked(0, 4'd3, 4'd1, "single_req0");
    tests++;
    if (p1 !== 6'd0 || rfd1 !== 1'b1) begin
      failed++;
      $display("[TB] FAIL single_req0 req1 state: p1=%0d rfd1=%b expected 0 and 1", p1, rfd1);
    end
  endtask

  task automatic test_simultaneous();
    apply_reset();
    pair_checked(4'd5, 4'd2, 4'd4, 4'd4, "simul_first");
    pair_checked(4'd1, 4'd1, 4'd2, 4'd2, "simul_second");
  endtask

  task automatic test_back_to_back();
    fall_delay = 0;
    rise_delay = 0;
    for (int i = 0; i < 16; i++) begin
      single_checked(0, 4'(i + 3), 4'(i + 1), "back_to_back");
    end
  endtask

  task automatic test_reset_mid();
    int n;
    bit seen;
    int lc, dc;
    logic [5:0] ps;
    bit ok;
    rise_delay = 30;
    a0 = 4'd7; b0 = 4'd6; dav0_ = 1'b0;
    seen = 1'b0; n = 0;
    while (n < 200 && !seen) begin
      @(negedge clock); n++;
      if (rfd0 == 1'b0) seen = 1'b1;
    end
    dav0_ = 1'b1;
    seen = 1'b0; n = 0;
    while (n < 200 && !seen) begin
      @(negedge clock); n++;
      if (u_dav_ == 1'b1 && u_rfd == 1'b0 && rfd0 == 1'b0) seen = 1'b1;
    end
    tests++;
    if (!seen) begin
      failed++;
      $display("[TB] FAIL reset_mid reach_release: not observed, expected within 200 cycles");
    end
    reset_ = 1'b0;
    #1;
    tests++;
    if ({u_dav_, rfd0, rfd1} !== 3'b111) begin
      failed++;
      $display("[TB] FAIL reset_mid flags: u_dav_,rfd0,rfd1=%b expected 111", {u_dav_, rfd0, rfd1});
    end
    tests++;
    if (p0 !== 6'd0 || p1 !== 6'd0) begin
      failed++;
      $display("[TB] FAIL reset_mid results: p0=%0d p1=%0d expected 0 0", p0, p1);
    end
    repeat (2) @(negedge clock);
    reset_ = 1'b1;
    lg_model = 1;
    rise_delay = 0;
    @(negedge clock);
    request(1, 4'd9, 4'd5, lc, dc, ps, ok);
    tests++;
    if (!ok || ps !== perim(4'd9, 4'd5)) begin
      failed++;
      $display("[TB] FAIL reset_mid after: done=%0d p1=%0d expected 1 and %0d", ok, ps, perim(4'd9, 4'd5));
    end
    lg_model = 1;
  endtask

  task automatic test_slow_unit();
    int lc0, lc1, dc0, dc1, n, bad;
    logic [5:0] ps0, ps1;
    bit ok0, ok1, req0_done, seen;
    rise_delay = 40;
    fall_delay = 1;
    req0_done = 1'b0;
    bad = 0;
    ok1 = 1'b0;
    ps1 = '0;
    fork
      begin
        request(0, 4'd6, 4'd3, lc0, dc0, ps0, ok0);
        req0_done = 1'b1;
      end
      begin
        seen = 1'b0; n = 0;
        while (n < 200 && !seen) begin
          @(negedge clock); n++;
          if (rfd0 == 1'b0) seen = 1'b1;
        end
        if (seen) begin
          fork
            request(1, 4'd2, 4'd7, lc1, dc1, ps1, ok1);
            begin
              while (!req0_done && n < 4000) begin
                @(negedge clock); n++;
                if (!req0_done && rfd1 !== 1'b1) bad++;
              end
            end
          join
        end
      end
    join
    tests++;
    if (!ok0 || ps0 !== perim(4'd6, 4'd3)) begin
      failed++;
      $display("[TB] FAIL slow_unit p0: done=%0d p0=%0d expected 1 and %0d", ok0, ps0, perim(4'd6, 4'd3));
    end
    tests++;
    if (lc0 <= 40) begin
      failed++;
      $display("[TB] FAIL slow_unit latency: rfd0 low %0d cycles expected more than 40", lc0);
    end
    tests++;
    if (bad != 0) begin
      failed++;
      $display("[TB] FAIL slow_unit pending: rfd1 low %0d cycles during req0 expected 0", bad);
    end
    tests++;
    if (!ok1 || ps1 !== perim(4'd2, 4'd7)) begin
      failed++;
      $display("[TB] FAIL slow_unit p1: done=%0d p1=%0d expected 1 and %0d", ok1, ps1, perim(4'd2, 4'd7));
    end
    lg_model = 1;
    rise_delay = 0;
    fall_delay = 0;
  endtask

  task automatic test_random();
    int mode;
    for (int r = 0; r < 24; r++) begin
      fall_delay = $urandom_range(0, 4);
      rise_delay = $urandom_range(0, 4);
      mode = $urandom_range(0, 2);
      if (mode == 0)
        single_checked(0, 4'($urandom), 4'($urandom), "random_req0");
      else if (mode == 1)
        single_checked(1, 4'($urandom), 4'($urandom), "random_req1");
      else
        pair_checked(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), "random_pair");
    end
    fall_delay = 0;
    rise_delay = 0;
  endtask

`ifdef PERIM_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int n, low;
    bit seen;
    logic [5:0] p0_before;
    p0_before = p0;
    unit_stuck = 1'b1;
    a0 = 4'd5; b0 = 4'd5; dav0_ = 1'b0;
    seen = 1'b0; n = 0;
    while (n < 200 && !seen) begin
      @(negedge clock); n++;
      if (rfd0 == 1'b0) seen = 1'b1;
    end
    dav0_ = 1'b1;
    dav1_ = 1'b0;
    seen = 1'b0; n = 0; low = 1;
    while (n < 200 && !seen) begin
      @(negedge clock); n++;
      if (rfd0 == 1'b1) seen = 1'b1; else low++;
    end
    tests++;
    if (!seen || err0 !== 1'b1) begin
      failed++;
      $display("[TB] FAIL timeout err0: rfd0_back=%0d err0=%b expected 1 and 1", seen, err0);
    end
    tests++;
    if (low < 20 || p0 !== p0_before) begin
      failed++;
      $display("[TB] FAIL timeout hold: low=%0d p0=%0d expected >=20 and %0d", low, p0, p0_before);
    end
    seen = 1'b0; n = 0;
    while (n < 10 && !seen) begin
      @(negedge clock); n++;
      if (rfd1 == 1'b0) seen = 1'b1;
    end
    tests++;
    if (!seen) begin
      failed++;
      $display("[TB] FAIL timeout next_grant: rfd1 stayed 1 expected 0 within 10 cycles");
    end
    dav1_ = 1'b1;
    unit_stuck = 1'b0;
    apply_reset();
    tests++;
    if (err0 !== 1'b0 || err1 !== 1'b0) begin
      failed++;
      $display("[TB] FAIL timeout clear: err0=%b err1=%b expected 0 0", err0, err1);
    end
  endtask
`endif

  initial begin
    reset_ = 1'b0;
    dav0_ = 1'b1; dav1_ = 1'b1;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    test_reset();
    test_single();
    test_simultaneous();
    test_back_to_back();
    test_reset_mid();
    test_slow_unit();
    test_random();
`ifdef PERIM_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
